// File: rtl/jzjpcc_pc_sequencer.sv
// Fetch-stage PC sequencer: hold / sequential / redirect selection, wrong-path squash,
// and BOOT/RUN/HALT control. Define JZJPCC_PC_SEQ_CT_COUNTER_EN to build the taken-transfer counter.
module jzjpcc_pc_sequencer #(
  parameter int unsigned PC_MAX_B = 31,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                stall,
  input  logic                pcCTWriteEnable,
  input  logic [PC_MAX_B:2]   controlTransferNewPC,
  input  logic                halt_request,
  input  logic                resume,
  output logic [PC_MAX_B:2]   pc_fetch,
  output logic                fetch_valid,
  output logic                halted,
  output logic [31:0]         ct_count
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [PC_MAX_B:2] RESET_WORD = RESET_PC[PC_MAX_B:2];
  localparam logic [PC_MAX_B:2] PC_ONE     = {{(PC_MAX_B-2){1'b0}}, 1'b1};

  logic [1:0]          state_q, state_d;
  logic [PC_MAX_B:2]   pc_q, pc_d;
  logic                fetch_valid_q, fetch_valid_d;
  logic                halted_q, halted_d;
  logic                ct_inc;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_valid_d = fetch_valid_q;
    halted_d      = halted_q;
    ct_inc        = 1'b0;
    case (state_q)
      ST_BOOT: begin
        fetch_valid_d = 1'b1;
        state_d       = ST_RUN;
      end
      ST_RUN: begin
        // halt beats stall beats redirect; a stalled redirect is re-presented later
        if (halt_request) begin
          fetch_valid_d = 1'b0;
          halted_d      = 1'b1;
          state_d       = ST_HALT;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (pcCTWriteEnable) begin
          pc_d          = controlTransferNewPC;
          fetch_valid_d = 1'b0;
          ct_inc        = 1'b1;
        end else begin
          pc_d          = pc_q + PC_ONE;
          fetch_valid_d = 1'b1;
        end
      end
      ST_HALT: begin
        fetch_valid_d = 1'b0;
        halted_d      = 1'b1;
        if (resume) begin
          fetch_valid_d = 1'b1;
          halted_d      = 1'b0;
          state_d       = ST_RUN;
        end
      end
      default: begin
        fetch_valid_d = 1'b0;
        halted_d      = 1'b0;
        state_d       = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_WORD;
      fetch_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_valid_q <= fetch_valid_d;
      halted_q      <= halted_d;
    end
  end

`ifdef JZJPCC_PC_SEQ_CT_COUNTER_EN
  logic [31:0] ct_count_q, ct_count_d;

  always_comb begin
    ct_count_d = ct_count_q;
    if (ct_inc) ct_count_d = ct_count_q + 32'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ct_count_q <= '0;
    else        ct_count_q <= ct_count_d;
  end

  assign ct_count = ct_count_q;
`else
  logic ct_inc_unused;
  assign ct_inc_unused = ct_inc;
  assign ct_count      = '0;
`endif

  assign pc_fetch    = pc_q;
  assign fetch_valid = fetch_valid_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_jzjpcc_pc_sequencer.sv
// Scoreboard bench for jzjpcc_pc_sequencer: directed corner cases plus random traffic
// checked against a behavioural model of the PC sequencing rules.
module tb_jzjpcc_pc_sequencer;

  localparam int unsigned PC_MAX_B = 31;
  localparam logic [31:0] RESET_PC = 32'h0000_0103;
  localparam longint      PC_MOD   = longint'(1) << (PC_MAX_B - 1);

  logic                clock = 1'b0;
  logic                reset = 1'b0;
  logic                stall = 1'b0;
  logic                pcCTWriteEnable = 1'b0;
  logic [PC_MAX_B:2]   controlTransferNewPC = '0;
  logic                halt_request = 1'b0;
  logic                resume = 1'b0;
  logic [PC_MAX_B:2]   pc_fetch;
  logic                fetch_valid;
  logic                halted;
  logic [31:0]         ct_count;

  jzjpcc_pc_sequencer #(.PC_MAX_B(PC_MAX_B), .RESET_PC(RESET_PC)) dut (
    .clock(clock), .reset(reset), .stall(stall), .pcCTWriteEnable(pcCTWriteEnable),
    .controlTransferNewPC(controlTransferNewPC), .halt_request(halt_request), .resume(resume),
    .pc_fetch(pc_fetch), .fetch_valid(fetch_valid), .halted(halted), .ct_count(ct_count)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    longint      pc;
    bit          fv;
    bit          hl;
    longint      ct;
  } exp_t;

  exp_t exp_q[$];
  int n_pass = 0;
  int n_total = 0;

  // Reference model: mode is one of "boot", "run", "halt".
  string  m_mode;
  longint m_pc;
  bit     m_fv, m_hl;
  longint m_ct;

  function automatic void model_reset();
    m_mode = "boot";
    m_pc   = longint'(RESET_PC) / 4 % PC_MOD;
    m_fv   = 0;
    m_hl   = 0;
    m_ct   = 0;
  endfunction

  function automatic void model_step(bit h, bit s, bit ct, longint tgt, bit r);
    if (m_mode == "boot") begin
      m_fv = 1; m_mode = "run";
    end else if (m_mode == "halt") begin
      if (r) begin m_hl = 0; m_fv = 1; m_mode = "run"; end
    end else if (h) begin
      m_fv = 0; m_hl = 1; m_mode = "halt";
    end else if (!s) begin
      if (ct) begin
        m_pc = tgt; m_fv = 0;
`ifdef JZJPCC_PC_SEQ_CT_COUNTER_EN
        m_ct = (m_ct + 1) % (longint'(1) << 32);
`endif
      end else begin
        m_pc = (m_pc + 1) % PC_MOD; m_fv = 1;
      end
    end
  endfunction

  function automatic void push_expected();
    exp_t e;
    e.cyc = cyc + 1; e.pc = m_pc; e.fv = m_fv; e.hl = m_hl; e.ct = m_ct;
    exp_q.push_back(e);
  endfunction

  task automatic check(string name, longint got, longint exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, exp);
  endtask

  // Monitor: compares the outputs against the entry scheduled for this edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock); #1;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        check("missed_entry", longint'(e.cyc), longint'(cyc));
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        check("pc_fetch",    longint'(pc_fetch),    e.pc);
        check("fetch_valid", longint'(fetch_valid), longint'(e.fv));
        check("halted",      longint'(halted),      longint'(e.hl));
        check("ct_count",    longint'(ct_count),    e.ct);
      end
    end
  end

  task automatic step(bit h, bit s, bit ct, longint tgt, bit r);
    halt_request         = h;
    stall                = s;
    pcCTWriteEnable      = ct;
    controlTransferNewPC = tgt[PC_MAX_B-2:0];
    resume               = r;
    model_step(h, s, ct, tgt, r);
    push_expected();
    @(posedge clock); #3;
  endtask

  task automatic do_reset(int n);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < n; i++) begin
      halt_request    = 1'($urandom_range(0, 1));
      pcCTWriteEnable = 1'($urandom_range(0, 1));
      push_expected();
      @(posedge clock); #3;
    end
    reset = 1'b1;
  endtask

  initial begin
    @(posedge clock); #3;
    do_reset(2);
    // BOOT ignores inputs; fetch_valid rises after it
    step(1, 1, 1, 30'h123, 1);
    step(0, 0, 0, 0, 0);
    // wrap from all-ones
    step(0, 0, 1, 30'h3FFF_FFFF, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // redirect 0x10 then 0x40, back to back
    step(0, 0, 1, 30'h10, 0);
    step(0, 0, 1, 30'h40, 0);
    step(0, 0, 0, 0, 0);
    // stall masks redirect, then redirect applies
    step(0, 1, 1, 30'h80, 0);
    step(0, 1, 1, 30'h80, 0);
    step(0, 0, 1, 30'h80, 0);
    // halt with redirect at 0x20, ignored inputs, resume with halt_request
    step(0, 0, 1, 30'h20, 0);
    step(1, 0, 1, 30'h99, 0);
    step(1, 1, 1, 30'h55, 0);
    step(0, 0, 1, 30'h66, 0);
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    // reset mid-run
    do_reset(3);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // random traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      longint tgt;
      if ($urandom_range(0, 199) == 0) begin
        do_reset(int'($urandom_range(1, 3)));
      end
      tgt = ($urandom_range(0, 7) == 0) ? (PC_MOD - 1 - longint'($urandom_range(0, 2)))
                                        : longint'($urandom()) % PC_MOD;
      step(bit'($urandom_range(0, 15) == 0), bit'($urandom_range(0, 3) == 0),
           bit'($urandom_range(0, 4) == 0), tgt, bit'($urandom_range(0, 2) == 0));
    end
    step(0, 0, 0, 0, 0);
    repeat (3) @(posedge clock);
    #2;
    if (exp_q.size() != 0) check("queue_drained", longint'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
